// File: rtl/alu_rs.sv
// ALU reservation station: dual-slot allocate, CDB wakeup, single issue.
// Define ALU_RS_AGE_ORDER_EN for oldest-ready select; default is lowest index.
package uarch_pkg;
  localparam int XLEN  = 32;
  localparam int TAG_W = 6;

  typedef struct packed {
    logic [TAG_W-1:0] rd_tag;
    logic [3:0]       alu_op;
    logic             rs1_rdy;
    logic [TAG_W-1:0] rs1_tag;
    logic [XLEN-1:0]  rs1_val;
    logic             rs2_rdy;
    logic [TAG_W-1:0] rs2_tag;
    logic [XLEN-1:0]  rs2_val;
  } renamed_inst_t;
endpackage

module alu_rs
  import uarch_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [1:0]                        alu_rs_we,
  input  renamed_inst_t                     alu_rs_entry0,
  input  renamed_inst_t                     alu_rs_entry1,
  output logic                              alu_rs_rdy,
  input  logic [NUM_CDB-1:0]                cdb_valid,
  input  logic [NUM_CDB-1:0][TAG_W-1:0]     cdb_tag,
  input  logic [NUM_CDB-1:0][XLEN-1:0]      cdb_value,
  output logic                              issue_valid,
  input  logic                              issue_rdy,
  output renamed_inst_t                     issue_inst,
  output logic [$clog2(DEPTH):0]            occupancy
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  renamed_inst_t    ent_q [DEPTH];
  renamed_inst_t    ent_d [DEPTH];
  logic             hold_q;
  logic [IW-1:0]    hold_idx_q;

  logic [DEPTH-1:0] ready;
  logic [IW-1:0]    idx0, idx1, pick_idx, sel_idx;
  logic             f0, f1, pick_vld;
  logic             wr0, wr1, fire;

  // Lower port index is applied last so port 0 wins a duplicate tag.
  function automatic renamed_inst_t wake(
    input renamed_inst_t                 e,
    input logic [NUM_CDB-1:0]            v,
    input logic [NUM_CDB-1:0][TAG_W-1:0] t,
    input logic [NUM_CDB-1:0][XLEN-1:0]  d
  );
    renamed_inst_t r;
    r = e;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (v[p] && !e.rs1_rdy && t[p] == e.rs1_tag) begin
        r.rs1_rdy = 1'b1;
        r.rs1_val = d[p];
      end
      if (v[p] && !e.rs2_rdy && t[p] == e.rs2_tag) begin
        r.rs2_rdy = 1'b1;
        r.rs2_val = d[p];
      end
    end
    return r;
  endfunction

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++)
      occupancy = occupancy + CW'(valid_q[i]);
  end

  assign alu_rs_rdy = occupancy <= CW'(DEPTH - 2);
  assign wr0 = alu_rs_we[0] & alu_rs_rdy & ~flush;
  assign wr1 = alu_rs_we[1] & alu_rs_rdy & ~flush;

  always_comb begin
    idx0 = '0;
    idx1 = '0;
    f0   = 1'b0;
    f1   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !f0) begin
        idx0 = IW'(i);
        f0   = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !f1 &&
          !(alu_rs_we[0] && IW'(i) == idx0)) begin
        idx1 = IW'(i);
        f1   = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      ready[i] = valid_q[i] & ent_q[i].rs1_rdy
               & ent_q[i].rs2_rdy;
  end

`ifdef ALU_RS_AGE_ORDER_EN
  // age_q[i][j]=1: entry i was allocated before entry j.
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic             oldest;

  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    oldest   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      oldest = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && !age_q[i][j])
          oldest = 1'b0;
      end
      if (oldest && !pick_vld) begin
        pick_idx = IW'(i);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    age_d = age_q;
    if (wr0) begin
      for (int j = 0; j < DEPTH; j++) begin
        age_d[idx0][j] = 1'b0;
        age_d[j][idx0] = 1'b1;
      end
    end
    if (wr1) begin
      for (int j = 0; j < DEPTH; j++) begin
        age_d[idx1][j] = 1'b0;
        age_d[j][idx1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) age_q <= '{default: '0};
    else              age_q <= age_d;
  end
`else
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !pick_vld) begin
        pick_idx = IW'(i);
        pick_vld = 1'b1;
      end
    end
  end
`endif

  // A stalled issue keeps its entry so later wakeups cannot reorder it.
  assign sel_idx     = hold_q ? hold_idx_q : pick_idx;
  assign issue_valid = hold_q | pick_vld;
  assign issue_inst  = ent_q[sel_idx];
  assign fire        = issue_valid & issue_rdy & ~flush;

  always_comb begin
    valid_d = valid_q;
    if (fire) valid_d[sel_idx] = 1'b0;
    if (wr0)  valid_d[idx0]    = 1'b1;
    if (wr1)  valid_d[idx1]    = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      ent_d[i] = wake(ent_q[i], cdb_valid, cdb_tag, cdb_value);
    if (wr0)
      ent_d[idx0] = wake(alu_rs_entry0, cdb_valid, cdb_tag, cdb_value);
    if (wr1)
      ent_d[idx1] = wake(alu_rs_entry1, cdb_valid, cdb_tag, cdb_value);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q    <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      valid_q    <= valid_d;
      hold_q     <= issue_valid & ~issue_rdy;
      hold_idx_q <= sel_idx;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: tb/tb_alu_rs.sv
// Testbench for alu_rs: directed scenarios plus randomized model comparison.
// Honors ALU_RS_AGE_ORDER_EN the same way as the design.
module tb_alu_rs;
  import uarch_pkg::*;

  localparam int DEPTH   = 8;
  localparam int NUM_CDB = 2;

  logic                          clk;
  logic                          rst;
  logic                          flush;
  logic [1:0]                    alu_rs_we;
  renamed_inst_t                 alu_rs_entry0;
  renamed_inst_t                 alu_rs_entry1;
  logic                          alu_rs_rdy;
  logic [NUM_CDB-1:0]            cdb_valid;
  logic [NUM_CDB-1:0][TAG_W-1:0] cdb_tag;
  logic [NUM_CDB-1:0][XLEN-1:0]  cdb_value;
  logic                          issue_valid;
  logic                          issue_rdy;
  renamed_inst_t                 issue_inst;
  logic [3:0]                    occupancy;

  int checks = 0;
  int fails  = 0;

  alu_rs #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .alu_rs_we    (alu_rs_we),
    .alu_rs_entry0(alu_rs_entry0),
    .alu_rs_entry1(alu_rs_entry1),
    .alu_rs_rdy   (alu_rs_rdy),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .issue_valid  (issue_valid),
    .issue_rdy    (issue_rdy),
    .issue_inst   (issue_inst),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic renamed_inst_t mk(
    input int rd, input bit r1, input int t1, input int v1,
    input bit r2, input int t2, input int v2);
    renamed_inst_t e;
    e.rd_tag  = TAG_W'(rd);
    e.alu_op  = 4'(rd);
    e.rs1_rdy = r1;
    e.rs1_tag = TAG_W'(t1);
    e.rs1_val = XLEN'(v1);
    e.rs2_rdy = r2;
    e.rs2_tag = TAG_W'(t2);
    e.rs2_val = XLEN'(v2);
    return e;
  endfunction

  function automatic renamed_inst_t rnd_inst();
    renamed_inst_t e;
    e.rd_tag  = TAG_W'($urandom);
    e.alu_op  = 4'($urandom);
    e.rs1_rdy = 1'($urandom_range(0, 1));
    e.rs1_tag = TAG_W'($urandom_range(0, 7));
    e.rs1_val = $urandom;
    e.rs2_rdy = 1'($urandom_range(0, 1));
    e.rs2_tag = TAG_W'($urandom_range(0, 7));
    e.rs2_val = $urandom;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    flush         = 1'b0;
    alu_rs_we     = 2'b00;
    alu_rs_entry0 = '0;
    alu_rs_entry1 = '0;
    cdb_valid     = '0;
    cdb_tag       = '0;
    cdb_value     = '0;
    issue_rdy     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    alu_rs_we     = 2'b11;
    alu_rs_entry0 = mk(1, 1, 0, 1, 1, 0, 2);
    alu_rs_entry1 = mk(2, 1, 0, 3, 1, 0, 4);
    tick();
    rst = 1'b0;
    idle();
    checks++;
    if (occupancy !== 4'd0) begin
      fails++; $display("FAIL reset_occ got=%0d exp=0", occupancy);
    end
    checks++;
    if (issue_valid !== 1'b0) begin
      fails++; $display("FAIL reset_ivalid got=%b exp=0", issue_valid);
    end
    checks++;
    if (alu_rs_rdy !== 1'b1) begin
      fails++; $display("FAIL reset_rdy got=%b exp=1", alu_rs_rdy);
    end
  endtask

  task automatic test_dual_write();
    do_reset();
    alu_rs_we     = 2'b11;
    alu_rs_entry0 = mk(1, 1, 0, 32'h11, 1, 0, 32'h22);
    alu_rs_entry1 = mk(2, 1, 0, 32'h33, 1, 0, 32'h44);
    tick();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || issue_inst.rd_tag !== 6'd1) begin
      fails++;
      $display("FAIL dual_issue got=%b/%0d exp=1/1", issue_valid, issue_inst.rd_tag);
    end
    checks++;
    if (occupancy !== 4'd2 || alu_rs_rdy !== 1'b1) begin
      fails++;
      $display("FAIL dual_occ got=%0d/%b exp=2/1", occupancy, alu_rs_rdy);
    end
    issue_rdy = 1'b1;
    tick();
    checks++;
    if (issue_inst.rd_tag !== 6'd2 || occupancy !== 4'd1) begin
      fails++;
      $display("FAIL dual_second got=%0d/%0d exp=2/1", issue_inst.rd_tag, occupancy);
    end
    tick();
    issue_rdy = 1'b0;
    checks++;
    if (occupancy !== 4'd0 || issue_valid !== 1'b0) begin
      fails++;
      $display("FAIL dual_drain got=%0d/%b exp=0/0", occupancy, issue_valid);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      alu_rs_we     = 2'b11;
      alu_rs_entry0 = mk(30 + 2 * k, 0, 10 + 2 * k, 0, 1, 0, 5);
      alu_rs_entry1 = mk(31 + 2 * k, 0, 11 + 2 * k, 0, 1, 0, 5);
      tick();
    end
    idle();
    checks++;
    if (occupancy !== 4'd8 || alu_rs_rdy !== 1'b0) begin
      fails++;
      $display("FAIL fill_full got=%0d/%b exp=8/0", occupancy, alu_rs_rdy);
    end
    alu_rs_we     = 2'b11;
    alu_rs_entry0 = mk(50, 1, 0, 1, 1, 0, 1);
    alu_rs_entry1 = mk(51, 1, 0, 1, 1, 0, 1);
    tick();
    idle();
    checks++;
    if (occupancy !== 4'd8 || issue_valid !== 1'b0) begin
      fails++;
      $display("FAIL fill_drop8 got=%0d/%b exp=8/0", occupancy, issue_valid);
    end
    cdb_valid    = 2'b01;
    cdb_tag[0]   = 6'd10;
    cdb_value[0] = 32'hCAFE;
    tick();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || issue_inst.rd_tag !== 6'd30) begin
      fails++;
      $display("FAIL fill_wake got=%b/%0d exp=1/30", issue_valid, issue_inst.rd_tag);
    end
    issue_rdy = 1'b1;
    tick();
    issue_rdy = 1'b0;
    checks++;
    if (occupancy !== 4'd7 || alu_rs_rdy !== 1'b0) begin
      fails++;
      $display("FAIL fill_occ7 got=%0d/%b exp=7/0", occupancy, alu_rs_rdy);
    end
    alu_rs_we     = 2'b11;
    alu_rs_entry0 = mk(52, 1, 0, 1, 1, 0, 1);
    alu_rs_entry1 = mk(53, 1, 0, 1, 1, 0, 1);
    tick();
    idle();
    checks++;
    if (occupancy !== 4'd7 || issue_valid !== 1'b0) begin
      fails++;
      $display("FAIL fill_drop7 got=%0d/%b exp=7/0", occupancy, issue_valid);
    end
  endtask

  task automatic test_wakeup();
    do_reset();
    alu_rs_we     = 2'b01;
    alu_rs_entry0 = mk(3, 0, 5, 0, 1, 0, 7);
    tick();
    idle();
    cdb_valid    = 2'b10;
    cdb_tag[1]   = 6'd5;
    cdb_value[1] = 32'hDEAD;
    #1;
    checks++;
    if (issue_valid !== 1'b0) begin
      fails++; $display("FAIL wake_early got=%b exp=0", issue_valid);
    end
    tick();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || issue_inst.rs1_val !== 32'hDEAD) begin
      fails++;
      $display("FAIL wake_val got=%b/%h exp=1/dead", issue_valid, issue_inst.rs1_val);
    end
    issue_rdy = 1'b1;
    tick();
    idle();
    alu_rs_we     = 2'b01;
    alu_rs_entry0 = mk(4, 1, 0, 1, 0, 7, 0);
    tick();
    idle();
    cdb_valid    = 2'b11;
    cdb_tag[0]   = 6'd7;
    cdb_tag[1]   = 6'd7;
    cdb_value[0] = 32'hAAAA;
    cdb_value[1] = 32'hBBBB;
    tick();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || issue_inst.rs2_val !== 32'hAAAA) begin
      fails++;
      $display("FAIL wake_prio got=%b/%h exp=1/aaaa", issue_valid, issue_inst.rs2_val);
    end
    issue_rdy = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_capture();
    do_reset();
    alu_rs_we     = 2'b01;
    alu_rs_entry0 = mk(6, 1, 0, 1, 0, 9, 0);
    cdb_valid     = 2'b01;
    cdb_tag[0]    = 6'd9;
    cdb_value[0]  = 32'h1234;
    tick();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || issue_inst.rs2_val !== 32'h1234 ||
        issue_inst.rs2_rdy !== 1'b1) begin
      fails++;
      $display("FAIL capture got=%b/%h exp=1/1234", issue_valid, issue_inst.rs2_val);
    end
    issue_rdy = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_stall();
    renamed_inst_t e1;
    do_reset();
    e1            = mk(2, 1, 0, 32'h55, 1, 0, 32'h66);
    alu_rs_we     = 2'b11;
    alu_rs_entry0 = mk(1, 0, 12, 0, 1, 0, 32'h77);
    alu_rs_entry1 = e1;
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (issue_valid !== 1'b1 || issue_inst !== e1) begin
        fails++;
        $display("FAIL stall_hold c=%0d got=%h exp=%h", c, issue_inst, e1);
      end
      if (c == 0) begin
        cdb_valid    = 2'b01;
        cdb_tag[0]   = 6'd12;
        cdb_value[0] = 32'h99;
      end
      tick();
      idle();
    end
    checks++;
    if (issue_inst !== e1 || occupancy !== 4'd2) begin
      fails++;
      $display("FAIL stall_after got=%0d/%0d exp=2/2", issue_inst.rd_tag, occupancy);
    end
    issue_rdy = 1'b1;
    tick();
    issue_rdy = 1'b0;
    checks++;
    if (occupancy !== 4'd1 || issue_inst.rd_tag !== 6'd1 ||
        issue_inst.rs1_val !== 32'h99) begin
      fails++;
      $display("FAIL stall_release got=%0d/%0d exp=1/1", occupancy, issue_inst.rd_tag);
    end
    issue_rdy = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      alu_rs_we     = 2'b11;
      alu_rs_entry0 = mk(60 + k, k == 0, 1 + k, 0, 1, 0, 0);
      alu_rs_entry1 = mk(63 + k, 0, 4 + k, 0, 1, 0, 0);
      tick();
    end
    idle();
    checks++;
    if (occupancy !== 4'd6) begin
      fails++; $display("FAIL flush_pre got=%0d exp=6", occupancy);
    end
    flush         = 1'b1;
    issue_rdy     = 1'b1;
    alu_rs_we     = 2'b11;
    alu_rs_entry0 = mk(20, 1, 0, 1, 1, 0, 1);
    alu_rs_entry1 = mk(21, 1, 0, 1, 1, 0, 1);
    #1;
    checks++;
    if (issue_valid !== 1'b1) begin
      fails++; $display("FAIL flush_ivalid got=%b exp=1", issue_valid);
    end
    tick();
    idle();
    checks++;
    if (occupancy !== 4'd0 || issue_valid !== 1'b0 || alu_rs_rdy !== 1'b1) begin
      fails++;
      $display("FAIL flush_post got=%0d/%b/%b exp=0/0/1", occupancy, issue_valid, alu_rs_rdy);
    end
  endtask

  task automatic test_age();
    logic [5:0] first_exp, second_exp;
`ifdef ALU_RS_AGE_ORDER_EN
    first_exp = 6'd43; second_exp = 6'd44;
`else
    first_exp = 6'd44; second_exp = 6'd43;
`endif
    do_reset();
    alu_rs_we     = 2'b11;
    alu_rs_entry0 = mk(40, 0, 20, 0, 1, 0, 0);
    alu_rs_entry1 = mk(41, 0, 21, 0, 1, 0, 0);
    tick();
    alu_rs_entry0 = mk(42, 0, 22, 0, 1, 0, 0);
    alu_rs_entry1 = mk(43, 0, 23, 0, 1, 0, 0);
    tick();
    idle();
    cdb_valid = 2'b11;
    cdb_tag[0] = 6'd20;
    cdb_tag[1] = 6'd21;
    tick();
    idle();
    cdb_valid  = 2'b01;
    cdb_tag[0] = 6'd22;
    issue_rdy  = 1'b1;
    tick();
    idle();
    issue_rdy = 1'b1;
    tick();
    tick();
    idle();
    checks++;
    if (occupancy !== 4'd1 || issue_valid !== 1'b0) begin
      fails++;
      $display("FAIL age_pre got=%0d/%b exp=1/0", occupancy, issue_valid);
    end
    alu_rs_we     = 2'b01;
    alu_rs_entry0 = mk(44, 1, 0, 0, 1, 0, 0);
    cdb_valid     = 2'b01;
    cdb_tag[0]    = 6'd23;
    tick();
    idle();
    checks++;
    if (issue_valid !== 1'b1 || issue_inst.rd_tag !== first_exp) begin
      fails++;
      $display("FAIL age_first got=%0d exp=%0d", issue_inst.rd_tag, first_exp);
    end
    issue_rdy = 1'b1;
    tick();
    checks++;
    if (issue_inst.rd_tag !== second_exp || occupancy !== 4'd1) begin
      fails++;
      $display("FAIL age_second got=%0d exp=%0d", issue_inst.rd_tag, second_exp);
    end
    tick();
    idle();
  endtask

  function automatic renamed_inst_t m_wake(input renamed_inst_t e);
    renamed_inst_t r;
    r = e;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (!r.rs1_rdy && cdb_valid[p] && cdb_tag[p] == e.rs1_tag) begin
        r.rs1_rdy = 1'b1; r.rs1_val = cdb_value[p];
      end
    end
    for (int p = 0; p < NUM_CDB; p++) begin
      if (!r.rs2_rdy && cdb_valid[p] && cdb_tag[p] == e.rs2_tag) begin
        r.rs2_rdy = 1'b1; r.rs2_val = cdb_value[p];
      end
    end
    return r;
  endfunction

  task automatic test_random();
    renamed_inst_t m_e [DEPTH];
    bit            m_v [DEPTH];
    bit            pre_v [DEPTH];
    int            m_seq [DEPTH];
    int            seq, m_hidx, occ_e, sel, a0, a1;
    bit            m_hold, iv, rdy_e, fire;
    do_reset();
    seq = 0; m_hold = 0; m_hidx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 0; m_seq[i] = 0; m_e[i] = '0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      flush         = ($urandom_range(0, 39) == 0);
      alu_rs_we     = 2'($urandom_range(0, 3));
      alu_rs_entry0 = rnd_inst();
      alu_rs_entry1 = rnd_inst();
      for (int p = 0; p < NUM_CDB; p++) begin
        cdb_valid[p] = 1'($urandom_range(0, 1));
        cdb_tag[p]   = TAG_W'($urandom_range(0, 7));
        cdb_value[p] = $urandom;
      end
      issue_rdy = ($urandom_range(0, 9) < 6);
      #1;
      occ_e = 0;
      for (int i = 0; i < DEPTH; i++) occ_e += int'(m_v[i]);
      rdy_e = (DEPTH - occ_e) >= 2;
      iv = 0; sel = 0;
      if (m_hold) begin
        iv = 1; sel = m_hidx;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (m_v[i] && m_e[i].rs1_rdy && m_e[i].rs2_rdy) begin
`ifdef ALU_RS_AGE_ORDER_EN
            if (!iv || m_seq[i] < m_seq[sel]) begin iv = 1; sel = i; end
`else
            if (!iv) begin iv = 1; sel = i; end
`endif
          end
        end
      end
      checks++;
      if (occupancy !== 4'(occ_e) || alu_rs_rdy !== rdy_e) begin
        fails++;
        $display("FAIL rand_occ cyc=%0d got=%0d/%b exp=%0d/%b",
                 cyc, occupancy, alu_rs_rdy, occ_e, rdy_e);
      end
      checks++;
      if (issue_valid !== iv) begin
        fails++;
        $display("FAIL rand_ivalid cyc=%0d got=%b exp=%b", cyc, issue_valid, iv);
      end
      if (iv) begin
        checks++;
        if (issue_inst !== m_e[sel]) begin
          fails++;
          $display("FAIL rand_inst cyc=%0d got=%h exp=%h", cyc, issue_inst, m_e[sel]);
        end
      end
      fire = iv && issue_rdy && !flush;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
        m_hold = 0;
      end else begin
        pre_v = m_v;
        for (int i = 0; i < DEPTH; i++)
          if (m_v[i]) m_e[i] = m_wake(m_e[i]);
        if (fire) m_v[sel] = 0;
        a0 = -1; a1 = -1;
        if (rdy_e && alu_rs_we[0]) begin
          for (int i = DEPTH - 1; i >= 0; i--) if (!pre_v[i]) a0 = i;
          m_v[a0] = 1; m_e[a0] = m_wake(alu_rs_entry0);
          m_seq[a0] = seq; seq++;
        end
        if (rdy_e && alu_rs_we[1]) begin
          for (int i = DEPTH - 1; i >= 0; i--) if (!pre_v[i] && i != a0) a1 = i;
          m_v[a1] = 1; m_e[a1] = m_wake(alu_rs_entry1);
          m_seq[a1] = seq; seq++;
        end
        m_hold = iv && !issue_rdy;
        m_hidx = sel;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    @(negedge clk);
    test_reset();
    test_dual_write();
    test_fill();
    test_wakeup();
    test_capture();
    test_stall();
    test_flush();
    test_age();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
